clock_edit_controller: RTL and testbench



---
 rtl/clock_edit_controller.sv | 197 +++++++++++++++++++
 tb/tb_clock_edit_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_edit_controller.sv
// Front-panel key sequencer: screen select, edit-field walk, +/- strobes, idle exit, blink.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the plus/minus keys.
module clock_edit_controller #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned IDLE_TIMEOUT  = 500000000,
    parameter int unsigned BLINK_PERIOD  = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       KeyMode,
    input  logic       KeyEdit,
    input  logic       KeyPlusIn,
    input  logic       KeyMinusIn,
    input  logic       Mode24t12,
    output logic [1:0] screen,
    output logic       EditMode,
    output logic [2:0] EditPos,
    output logic       KeyPlus,
    output logic       KeyMinus,
    output logic       blink
);
    typedef enum logic {ST_VIEW = 1'b0, ST_EDIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_PERIOD - 1);

    if (BLINK_PERIOD == 0 || IDLE_TIMEOUT == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("clock_edit_controller: timing parameters must be non-zero");
    end

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_screen, w_screen_nxt;
    logic             r_edit_mode;
    logic [2:0]       r_pos, w_pos_nxt;
    logic             r_plus, w_plus_nxt;
    logic             r_minus, w_minus_nxt;
    logic             r_blink, w_blink_nxt;
    logic [CNT_W-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic [3:0]       r_key_prev;
    logic             w_exit;
    logic             w_strobe;

`ifdef AUTO_REPEAT_EN
    // Reload places the next repeat exactly REPEAT_PERIOD cycles after the previous one.
    localparam logic [CNT_W-1:0] REP_FIRE   = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_RELOAD = (REPEAT_PERIOD < REPEAT_DELAY) ?
                                              CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1) : CNT_W'(1);
    logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
`endif

    // Press edges, prioritised mode > edit > plus/minus
    logic [3:0] w_keys, w_press;
    logic       w_mode_ev, w_edit_ev, w_plus_ev, w_minus_ev, w_any_ev, w_single_hold;
    assign w_keys        = {KeyMode, KeyEdit, KeyPlusIn, KeyMinusIn};
    assign w_press       = r_key_prev & ~w_keys;
    assign w_mode_ev     = w_press[3];
    assign w_edit_ev     = w_press[2] & ~w_press[3];
    assign w_plus_ev     = w_press[1] & ~(|w_press[3:2]);
    assign w_minus_ev    = w_press[0] & ~(|w_press[3:2]);
    assign w_any_ev      = |w_press;
    assign w_single_hold = KeyPlusIn ^ KeyMinusIn;

    always_comb begin
        w_state_nxt     = r_state;
        w_screen_nxt    = r_screen;
        w_pos_nxt       = r_pos;
        w_plus_nxt      = 1'b1;
        w_minus_nxt     = 1'b1;
        w_blink_nxt     = r_blink;
        w_blink_cnt_nxt = r_blink_cnt;
        w_idle_cnt_nxt  = r_idle_cnt;
        w_exit          = 1'b0;
        w_strobe        = 1'b0;
`ifdef AUTO_REPEAT_EN
        w_rep_cnt_nxt   = '0;
`endif
        case (r_state)
            ST_VIEW: begin
                w_blink_nxt     = 1'b1;
                w_blink_cnt_nxt = '0;
                w_idle_cnt_nxt  = '0;
                w_pos_nxt       = 3'd0;
                if (w_mode_ev) begin
                    w_screen_nxt = r_screen + 2'd1;
                end else if (w_edit_ev && r_screen != 2'd3) begin
                    w_state_nxt = ST_EDIT;
                end
            end
            ST_EDIT: begin
                w_idle_cnt_nxt = (r_idle_cnt == IDLE_LAST) ? r_idle_cnt : r_idle_cnt + CNT_W'(1);
                if (w_any_ev) begin
                    w_idle_cnt_nxt = '0;
                end
                if (r_blink_cnt >= BLINK_LAST) begin
                    w_blink_nxt     = ~r_blink;
                    w_blink_cnt_nxt = '0;
                end else begin
                    w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
                end

                if (w_mode_ev) begin
                    w_exit = 1'b1;
                end else if (w_edit_ev) begin
                    if (r_pos == 3'd5) begin
                        if (r_screen == 2'd0 && Mode24t12) w_pos_nxt = 3'd7;
                        else                               w_exit    = 1'b1;
                    end else if (r_pos == 3'd7) begin
                        w_exit = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos + 3'd1;
                    end
                end else begin
                    if (w_plus_ev && KeyMinusIn) begin
                        w_plus_nxt = 1'b0;
                        w_strobe   = 1'b1;
`ifdef AUTO_REPEAT_EN
                        w_rep_cnt_nxt = CNT_W'(1);
`endif
                    end else if (w_minus_ev && KeyPlusIn) begin
                        w_minus_nxt = 1'b0;
                        w_strobe    = 1'b1;
`ifdef AUTO_REPEAT_EN
                        w_rep_cnt_nxt = CNT_W'(1);
                    end else if (w_single_hold && r_rep_cnt == REP_FIRE) begin
                        w_plus_nxt    = KeyPlusIn;
                        w_minus_nxt   = KeyMinusIn;
                        w_strobe      = 1'b1;
                        w_rep_cnt_nxt = REP_RELOAD;
                    end else if (w_single_hold && r_rep_cnt != '0) begin
                        w_rep_cnt_nxt = r_rep_cnt + CNT_W'(1);
`endif
                    end

                    if (w_strobe) begin
                        w_blink_nxt     = 1'b1;
                        w_blink_cnt_nxt = '0;
                        w_idle_cnt_nxt  = '0;
                    end else if (!w_any_ev && r_idle_cnt == IDLE_LAST) begin
                        w_exit = 1'b1;
                    end else if (r_pos == 3'd7 && !Mode24t12) begin
                        w_pos_nxt = 3'd0;
                    end
                end

                if (w_exit) begin
                    w_state_nxt     = ST_VIEW;
                    w_pos_nxt       = 3'd0;
                    w_blink_nxt     = 1'b1;
                    w_blink_cnt_nxt = '0;
                    w_idle_cnt_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_VIEW;
            r_screen    <= 2'd0;
            r_edit_mode <= 1'b0;
            r_pos       <= 3'd0;
            r_plus      <= 1'b1;
            r_minus     <= 1'b1;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
            r_idle_cnt  <= '0;
            r_key_prev  <= 4'hF;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_screen    <= w_screen_nxt;
            r_edit_mode <= (w_state_nxt == ST_EDIT);
            r_pos       <= w_pos_nxt;
            r_plus      <= w_plus_nxt;
            r_minus     <= w_minus_nxt;
            r_blink     <= w_blink_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_idle_cnt  <= w_idle_cnt_nxt;
            r_key_prev  <= w_keys;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt   <= w_rep_cnt_nxt;
`endif
        end
    end

    assign screen   = r_screen;
    assign EditMode = r_edit_mode;
    assign EditPos  = r_pos;
    assign KeyPlus  = r_plus;
    assign KeyMinus = r_minus;
    assign blink    = r_blink;
endmodule

// File: tb/tb_clock_edit_controller.sv
// Directed bench for clock_edit_controller with short timing parameters.
module tb_clock_edit_controller;
    localparam int K_MODE  = 3;
    localparam int K_EDIT  = 2;
    localparam int K_PLUS  = 1;
    localparam int K_MINUS = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] keys;
    logic       mode24;
    logic [1:0] screen;
    logic       edit_mode;
    logic [2:0] edit_pos;
    logic       key_plus;
    logic       key_minus;
    logic       blink;

    int n_cmp = 0;
    int n_err = 0;

    clock_edit_controller #(
        .CNT_W(32), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .IDLE_TIMEOUT(50), .BLINK_PERIOD(6)
    ) dut (
        .clk(clk), .reset(reset),
        .KeyMode(keys[K_MODE]), .KeyEdit(keys[K_EDIT]),
        .KeyPlusIn(keys[K_PLUS]), .KeyMinusIn(keys[K_MINUS]),
        .Mode24t12(mode24),
        .screen(screen), .EditMode(edit_mode), .EditPos(edit_pos),
        .KeyPlus(key_plus), .KeyMinus(key_minus), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input int k);
        keys[k] = 1'b0;
        step();
    endtask

    task automatic release_all();
        keys = 4'hF;
        step();
    endtask

    initial begin
        int         exp_pos24 [8] = '{0, 1, 2, 3, 4, 5, 7, 0};
        int         exp_pos12 [7] = '{0, 1, 2, 3, 4, 5, 0};
        int         exp_scr   [5] = '{1, 2, 3, 0, 1};
        logic [19:0] obs_strobe;
        logic [19:0] exp_strobe;
        logic [49:0] obs_blink;
        logic [49:0] exp_blink;

        reset  = 1'b1;
        keys   = 4'hF;
        mode24 = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_screen", 64'(screen), 64'd0);
        check("rst_editmode", 64'(edit_mode), 64'd0);
        check("rst_pos", 64'(edit_pos), 64'd0);
        check("rst_plus", 64'(key_plus), 64'd1);
        check("rst_minus", 64'(key_minus), 64'd1);
        check("rst_blink", 64'(blink), 64'd1);

        // Screen cycling in VIEW
        for (int i = 0; i < 5; i++) begin
            tap(K_MODE);
            check("view_screen", 64'(screen), 64'(exp_scr[i]));
            check("view_editmode", 64'(edit_mode), 64'd0);
            release_all();
        end
        tap(K_PLUS);
        check("view_plus_nostrobe", 64'(key_plus), 64'd1);
        release_all();
        tap(K_MINUS);
        check("view_minus_nostrobe", 64'(key_minus), 64'd1);
        release_all();
        for (int i = 0; i < 3; i++) begin
            tap(K_MODE);
            release_all();
        end
        check("screen_back_to_0", 64'(screen), 64'd0);

        // Field walk, 12h display shows the AM/PM field
        mode24 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tap(K_EDIT);
            check("walk12_pos", 64'(edit_pos), 64'(exp_pos24[i]));
            check("walk12_mode", 64'(edit_mode), (i < 7) ? 64'd1 : 64'd0);
            release_all();
        end
        mode24 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tap(K_EDIT);
            check("walk24_pos", 64'(edit_pos), 64'(exp_pos12[i]));
            check("walk24_mode", 64'(edit_mode), (i < 6) ? 64'd1 : 64'd0);
            release_all();
        end

        // Leaving 12h mode while on the AM/PM field
        mode24 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tap(K_EDIT);
            release_all();
        end
        check("pos7_reached", 64'(edit_pos), 64'd7);
        mode24 = 1'b0;
        step();
        check("pos7_drop_pos", 64'(edit_pos), 64'd0);
        check("pos7_drop_mode", 64'(edit_mode), 64'd1);
        tap(K_MODE);
        check("edit_mode_exit", 64'(edit_mode), 64'd0);
        check("edit_mode_keeps_screen", 64'(screen), 64'd0);
        release_all();

        // Stopwatch screen cannot be edited
        for (int i = 0; i < 3; i++) begin
            tap(K_MODE);
            release_all();
        end
        tap(K_EDIT);
        check("sw_no_edit", 64'(edit_mode), 64'd0);
        release_all();
        tap(K_MODE);
        release_all();

        // Single strobe and blink restore
        tap(K_EDIT);
        release_all();
        for (int i = 0; i < 5; i++) step();
        check("blink_off_before", 64'(blink), 64'd0);
        keys[K_PLUS] = 1'b0;
        step();
        check("strobe_low", 64'(key_plus), 64'd0);
        check("strobe_blink", 64'(blink), 64'd1);
        check("strobe_minus_idle", 64'(key_minus), 64'd1);
        step();
        check("strobe_one_cycle", 64'(key_plus), 64'd1);
        release_all();
        tap(K_MINUS);
        check("minus_strobe", 64'(key_minus), 64'd0);
        release_all();
        check("minus_strobe_end", 64'(key_minus), 64'd1);

        // Second key pressed while first held: no strobe
        keys[K_PLUS] = 1'b0;
        step();
        keys[K_MINUS] = 1'b0;
        step();
        check("both_minus", 64'(key_minus), 64'd1);
        check("both_plus", 64'(key_plus), 64'd1);
        release_all();
        tap(K_MODE);
        release_all();

        // Held plus
        tap(K_EDIT);
        release_all();
        keys[K_PLUS] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            obs_strobe[i] = ~key_plus;
        end
`ifdef AUTO_REPEAT_EN
        exp_strobe = 20'h11101;
`else
        exp_strobe = 20'h00001;
`endif
        check("hold_strobes", 64'(obs_strobe), 64'(exp_strobe));
        release_all();
        tap(K_MODE);
        release_all();

        // Idle timeout and blink cadence
        tap(K_EDIT);
        keys = 4'hF;
        for (int k = 1; k <= 50; k++) begin
            step();
            obs_blink[k-1] = blink;
            exp_blink[k-1] = (k == 50) ? 1'b1 : (((k / 6) % 2) == 0);
            if (k == 49) check("idle_still_edit", 64'(edit_mode), 64'd1);
            if (k == 50) begin
                check("idle_exit", 64'(edit_mode), 64'd0);
                check("idle_exit_pos", 64'(edit_pos), 64'd0);
            end
        end
        check("blink_pattern", 64'(obs_blink), 64'(exp_blink));

        // Mode and edit together: mode wins
        keys[K_MODE] = 1'b0;
        keys[K_EDIT] = 1'b0;
        step();
        check("coinc_screen", 64'(screen), 64'd1);
        check("coinc_editmode", 64'(edit_mode), 64'd0);
        release_all();
        check("coinc_no_late_edit", 64'(edit_mode), 64'd0);

        // Reset during a minus press in EDIT
        tap(K_EDIT);
        release_all();
        check("pre_reset_edit", 64'(edit_mode), 64'd1);
        keys[K_MINUS] = 1'b0;
        reset = 1'b1;
        step();
        check("rst2_screen", 64'(screen), 64'd0);
        check("rst2_editmode", 64'(edit_mode), 64'd0);
        check("rst2_pos", 64'(edit_pos), 64'd0);
        check("rst2_minus", 64'(key_minus), 64'd1);
        check("rst2_plus", 64'(key_plus), 64'd1);
        check("rst2_blink", 64'(blink), 64'd1);
        keys  = 4'hF;
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
